// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   UART receive engine. Synchronizes the serial line, detects a start bit,
//   samples each bit in its middle using an oversampling tick, optionally
//   checks a parity bit, checks the stop bit(s) and presents the word with a
//   one-clock done strobe plus error flags.
//
// Ports
//   clk        : system clock, all logic on posedge
//   reset      : asynchronous, active-low reset
//   rx_tick    : oversample enable, OVERSAMPLE pulses per bit time
//   rx         : serial line (idle high), asynchronous to clk
//   rx_dout    : received word, held until the next rx_done
//   rx_done    : one-clock pulse when a frame completes
//   parity_err : parity mismatch on the last frame (0 when no parity bit)
//   frame_err  : a stop-bit sample was 0 on the last frame
//   busy       : high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int SB_TICKS   = 1,
  parameter int IS_PARITY  = 0,
  parameter int PARITY     = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_MID   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
  localparam logic          SB_LAST    = 1'(SB_TICKS - 1);
  localparam logic          PARITY_BIT = 1'(PARITY);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 rx_meta_reg, rx_s;
  logic [2:0]           state_reg, state_next;
  logic [TW-1:0]        tick_cnt_reg, tick_cnt_next;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic                 sb_cnt_reg, sb_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 pe_acc_reg, pe_acc_next;
  logic                 fe_acc_reg, fe_acc_next;
  logic [DATA_BITS-1:0] dout_reg, dout_next;
  logic                 done_reg, done_next;
  logic                 perr_reg, perr_next;
  logic                 ferr_reg, ferr_next;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s        <= rx_meta_reg;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    sb_cnt_next   = sb_cnt_reg;
    shift_next    = shift_reg;
    pe_acc_next   = pe_acc_reg;
    fe_acc_next   = fe_acc_reg;
    dout_next     = dout_reg;
    done_next     = 1'b0;
    perr_next     = perr_reg;
    ferr_next     = ferr_reg;

    case (state_reg)
      S_IDLE: begin
        // Start detection does not wait for a tick, so a start edge right
        // after a frame loses no oversampling phase.
        if (!rx_s) begin
          state_next    = S_START;
          tick_cnt_next = '0;
        end
      end

      S_START: begin
        if (rx_tick) begin
          if (tick_cnt_reg == TICK_MID) begin
            tick_cnt_next = '0;
            if (!rx_s) begin
              state_next   = S_DATA;
              bit_cnt_next = '0;
              pe_acc_next  = 1'b0;
              fe_acc_next  = 1'b0;
            end else begin
              // Line went back high before mid-bit: glitch, outputs untouched.
              state_next = S_IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (rx_tick) begin
          if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_next = '0;
            // LSB arrives first, so shift in from the top.
            shift_next    = {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_cnt_next  = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == BIT_LAST) begin
              bit_cnt_next = '0;
              sb_cnt_next  = 1'b0;
              state_next   = (IS_PARITY != 0) ? S_PARITY : S_STOP;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (rx_tick) begin
          if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_next = '0;
            // Mismatch when the received bit differs from XOR(data)^PARITY.
            pe_acc_next   = rx_s ^ (^shift_reg) ^ PARITY_BIT;
            state_next    = S_STOP;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (rx_tick) begin
          if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_next = '0;
            fe_acc_next   = fe_acc_reg | ~rx_s;
            if (sb_cnt_reg == SB_LAST) begin
              // Publish at the middle of the last stop bit.
              state_next = S_IDLE;
              dout_next  = shift_reg;
              done_next  = 1'b1;
              ferr_next  = fe_acc_reg | ~rx_s;
              perr_next  = (IS_PARITY != 0) && pe_acc_reg;
            end else begin
              sb_cnt_next = 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      sb_cnt_reg   <= 1'b0;
      shift_reg    <= '0;
      pe_acc_reg   <= 1'b0;
      fe_acc_reg   <= 1'b0;
      dout_reg     <= '0;
      done_reg     <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      sb_cnt_reg   <= sb_cnt_next;
      shift_reg    <= shift_next;
      pe_acc_reg   <= pe_acc_next;
      fe_acc_reg   <= fe_acc_next;
      dout_reg     <= dout_next;
      done_reg     <= done_next;
      perr_reg     <= perr_next;
      ferr_reg     <= ferr_next;
    end
  end

  assign rx_dout    = dout_reg;
  assign rx_done    = done_reg;
  assign parity_err = perr_reg;
  assign frame_err  = ferr_reg;
  assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//   Drives three receiver configurations (8N1/16x, 8E2/16x, 8O1/8x) with
//   directed and random frames and compares each received frame against
//   the expected word and flags derived from the frame's line levels.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

  logic            clk = 1'b0;
  logic            reset;
  logic            rx_tick = 1'b0;
  logic [2:0]      rx_l;
  logic [2:0][7:0] dout;
  logic [2:0]      done, perr, ferr, busy;

  int checks = 0;
  int errors = 0;
  int tick_div = 2;

  int          done_cnt [3] = '{default: 0};
  logic [9:0]  cap      [3] = '{default: '0};
  logic [9:0]  exp_out  [3] = '{default: '0};

  always #5 clk = ~clk;

  // Configuration of each instance: 0 = 8N1 x16, 1 = 8E2 x16, 2 = 8O1 x8.
  function automatic int cfg_os(input int i);  return (i == 2) ? 8 : 16; endfunction
  function automatic int cfg_sb(input int i);  return (i == 1) ? 2 : 1;  endfunction
  function automatic int cfg_isp(input int i); return (i == 0) ? 0 : 1;  endfunction
  function automatic int cfg_par(input int i); return (i == 2) ? 1 : 0;  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      uart_receiver #(
        .DATA_BITS (8),
        .SB_TICKS  ((gi == 1) ? 2 : 1),
        .IS_PARITY ((gi == 0) ? 0 : 1),
        .PARITY    ((gi == 2) ? 1 : 0),
        .OVERSAMPLE((gi == 2) ? 8 : 16)
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .rx_tick   (rx_tick),
        .rx        (rx_l[gi]),
        .rx_dout   (dout[gi]),
        .rx_done   (done[gi]),
        .parity_err(perr[gi]),
        .frame_err (ferr[gi]),
        .busy      (busy[gi])
      );
    end
  endgenerate

  // Oversample tick: one clk wide, every tick_div clocks (1 = every clock).
  initial begin
    int tcnt = 0;
    forever begin
      @(negedge clk);
      rx_tick = (tcnt == 0);
      tcnt = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
    end
  end

  // Count done pulses and capture what each pulse presented.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i]) begin
        done_cnt[i] <= done_cnt[i] + 1;
        cap[i]      <= {dout[i], perr[i], ferr[i]};
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!rx_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive_bit(input int idx, input logic val, input int ticks);
    rx_l[idx] = val;
    wait_ticks(ticks);
  endtask

  // Sends one frame; a stop bit given as 0 is held low past its middle and
  // then released, so the line is high again before the frame ends.
  task automatic send_frame(input int idx, input logic [7:0] data, input logic pbit,
                            input logic [1:0] stops);
    int   os   = cfg_os(idx);
    int   base = done_cnt[idx];
    logic e_perr, e_ferr;
    e_ferr = 1'b0;
    drive_bit(idx, 1'b0, os);
    for (int i = 0; i < 8; i++) drive_bit(idx, data[i], os);
    if (cfg_isp(idx) != 0) drive_bit(idx, pbit, os);
    for (int s = 0; s < cfg_sb(idx); s++) begin
      if (stops[s]) begin
        drive_bit(idx, 1'b1, os);
      end else begin
        e_ferr = 1'b1;
        drive_bit(idx, 1'b0, os / 2 + 2);
        drive_bit(idx, 1'b1, os / 2 - 2);
      end
    end
    e_perr = (cfg_isp(idx) != 0) && (pbit != ((^data) ^ 1'(cfg_par(idx))));
    // A low stop bit leaves the receiver chasing a possible break; give it a
    // quiet bit time to settle back to idle.
    if (e_ferr) drive_bit(idx, 1'b1, os);
    exp_out[idx] = {data, e_perr, e_ferr};
    check_eq("done_pulses", done_cnt[idx] - base, 1);
    check_eq("captured", 32'(cap[idx]), 32'(exp_out[idx]));
    check_eq("held", 32'({dout[idx], perr[idx], ferr[idx]}), 32'(exp_out[idx]));
    check_eq("busy_idle", 32'(busy[idx]), 0);
    $display("frame dut%0d data=%02h pbit=%0b stops=%02b -> dout=%02h perr=%0b ferr=%0b",
             idx, data, pbit, stops, dout[idx], perr[idx], ferr[idx]);
  endtask

  task automatic glitch(input int idx, input int g);
    int base = done_cnt[idx];
    drive_bit(idx, 1'b0, g);
    drive_bit(idx, 1'b1, cfg_os(idx) + 2);
    check_eq("glitch_no_done", done_cnt[idx] - base, 0);
    check_eq("glitch_hold", 32'({dout[idx], perr[idx], ferr[idx]}), 32'(exp_out[idx]));
    check_eq("glitch_busy", 32'(busy[idx]), 0);
    $display("glitch dut%0d low=%0d ticks -> dout=%02h", idx, g, dout[idx]);
  endtask

  initial begin
    int          idx, base;
    logic [7:0]  data;
    logic        pbit;
    logic [1:0]  stops;

    reset = 1'b0;
    rx_l  = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      check_eq("reset_state", 32'({dout[i], done[i], perr[i], ferr[i], busy[i]}), 0);
    reset = 1'b1;
    wait_ticks(4);

    // 8N1 frame 0xA5.
    send_frame(0, 8'hA5, 1'b0, 2'b11);
    // Short low pulse is a false start.
    glitch(0, 4);
    // Bad stop bit, then a clean frame clears frame_err.
    send_frame(0, 8'h3C, 1'b0, 2'b10);
    send_frame(0, 8'h3C, 1'b0, 2'b11);
    // Even parity: 0x07 needs parity bit 1; bit 0 is a mismatch.
    send_frame(1, 8'h07, 1'b1, 2'b11);
    send_frame(1, 8'h07, 1'b0, 2'b11);
    // Odd parity: 0x07 needs parity bit 0.
    send_frame(2, 8'h07, 1'b0, 2'b11);
    // Two stop bits, back-to-back frames with no idle gap.
    send_frame(1, 8'h00, 1'b0, 2'b11);
    send_frame(1, 8'hFF, 1'b0, 2'b11);

    // Reset in the middle of data bit 4 of 0x55.
    base = done_cnt[0];
    drive_bit(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'(i % 2 == 0), 16);
    drive_bit(0, 1'b1, 8);
    check_eq("busy_mid_frame", 32'(busy[0]), 1);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("reset_mid_frame", 32'({dout[i], done[i], perr[i], ferr[i], busy[i]}), 0);
      exp_out[i] = '0;
    end
    rx_l[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_ticks(4);
    check_eq("aborted_no_done", done_cnt[0] - base, 0);
    send_frame(0, 8'h81, 1'b0, 2'b11);

    // Random frames across all configurations and tick rates.
    for (int it = 0; it < 45; it++) begin
      idx      = int'($urandom_range(0, 2));
      tick_div = int'($urandom_range(1, 3));
      wait_ticks(3);
      if ($urandom_range(0, 5) == 0) glitch(idx, int'($urandom_range(1, cfg_os(idx) / 4)));
      data  = 8'($urandom);
      pbit  = (^data) ^ 1'(cfg_par(idx)) ^ ($urandom_range(0, 3) == 0);
      stops = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
      send_frame(idx, data, pbit, stops);
      wait_ticks(int'($urandom_range(0, cfg_os(idx))));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
